// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: result source encoding,
// load funct3 codes, default sizing and the retire popcount.
package wb_pkg;
    localparam int LANES_DEF = 2;
    localparam int XLEN_DEF  = 32;

    typedef enum logic [1:0] {
        SRC_ALU     = 2'b00,
        SRC_LOAD    = 2'b01,
        SRC_LINK    = 2'b10,
        SRC_ALU_ALT = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Lanes are zero-extended to 32 bits by the caller, so up to 32 lanes fit.
    function automatic logic [63:0] popcount(input logic [31:0] v);
        logic [63:0] n;
        n = '0;
        for (int k = 0; k < 32; k++) n = n + 64'(v[k]);
        return n;
    endfunction
endpackage

// File: rtl/load_extend.sv
// Per-lane load data extraction: picks the addressed byte/halfword from the
// loaded word and sign- or zero-extends it according to funct3.
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = 8'(word >> {off, 3'b000});
    assign h = 16'(word >> {off[1], 4'b0000});

    always_comb begin
        ext = word;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, b};
            F3_LH:   ext = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, h};
            default: ext = word;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// N-lane MEM/WB register with result select, load extension, same-cycle
// write-after-write suppression between lanes and a retired-instruction counter.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        StallW,
    input  logic                        FlushW,
    input  logic [LANES-1:0]            ValidM,
    input  logic [LANES-1:0]            RegWriteM,
    input  logic [LANES-1:0][4:0]       RdM,
    input  logic [LANES-1:0][1:0]       ResultSrcM,
    input  logic [LANES-1:0][2:0]       Funct3M,
    input  logic [LANES-1:0][XLEN-1:0]  ALUResultM,
    input  logic [LANES-1:0][XLEN-1:0]  ReadDataM,
    input  logic [LANES-1:0][XLEN-1:0]  PCLinkM,
    output logic [LANES-1:0][XLEN-1:0]  ResultW,
    output logic [LANES-1:0][4:0]       RdW,
    output logic [LANES-1:0]            RegWriteW,
    output logic [LANES-1:0]            ValidW,
    output logic [63:0]                 InstretW
);
    logic [LANES-1:0]            valid_q, rw_q, killed;
    logic [LANES-1:0][4:0]       rd_q;
    logic [LANES-1:0][1:0]       src_q;
    logic [LANES-1:0][2:0]       f3_q;
    logic [LANES-1:0][XLEN-1:0]  alu_q, rdata_q, link_q, ext;
    logic [LANES-1:0][LANES-1:0] hit;
    logic [63:0]                 instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            rw_q      <= '0;
            rd_q      <= '0;
            src_q     <= '0;
            f3_q      <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            link_q    <= '0;
            instret_q <= '0;
        end else begin
            // Count what is leaving W now; flush only affects what enters.
            if (!StallW) instret_q <= instret_q + popcount(32'(valid_q));
            if (FlushW)      valid_q <= '0;
            else if (!StallW) valid_q <= ValidM;
            if (!StallW) begin
                rw_q    <= RegWriteM;
                rd_q    <= RdM;
                src_q   <= ResultSrcM;
                f3_q    <= Funct3M;
                alu_q   <= ALUResultM;
                rdata_q <= ReadDataM;
                link_q  <= PCLinkM;
            end
        end
    end

    // hit[i][j]: a younger lane j writes the same nonzero rd as lane i.
    for (genvar i = 0; i < LANES; i++) begin : g_kill
        for (genvar j = 0; j < LANES; j++) begin : g_pair
            if (j > i) begin : g_young
                assign hit[i][j] = valid_q[j] & rw_q[j] & (rd_q[j] == rd_q[i])
                                 & (rd_q[j] != 5'd0);
            end else begin : g_none
                assign hit[i][j] = 1'b0;
            end
        end
        assign killed[i] = |hit[i];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        load_extend #(.XLEN(XLEN)) u_ext (
            .word   (rdata_q[i]),
            .off    (alu_q[i][1:0]),
            .funct3 (f3_q[i]),
            .ext    (ext[i])
        );
        assign ResultW[i]   = (src_q[i] == SRC_LOAD) ? ext[i]
                            : (src_q[i] == SRC_LINK) ? link_q[i] : alu_q[i];
        assign RegWriteW[i] = valid_q[i] & rw_q[i] & (rd_q[i] != 5'd0)
                            & ~StallW & ~killed[i];
    end

    assign RdW      = rd_q;
    assign ValidW   = valid_q;
    assign InstretW = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage (LANES=2, XLEN=32): vector table through a
// scoreboard queue, plus hand sequences for reset, stall, flush and wrap.
module tb_writeback_stage;
    logic             clk = 1'b0;
    logic             rst, StallW, FlushW;
    logic [1:0]       ValidM, RegWriteM, RegWriteW, ValidW;
    logic [1:0][4:0]  RdM, RdW;
    logic [1:0][1:0]  ResultSrcM;
    logic [1:0][2:0]  Funct3M;
    logic [1:0][31:0] ALUResultM, ReadDataM, PCLinkM, ResultW;
    logic [63:0]      InstretW;

    writeback_stage #(.LANES(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .RdM(RdM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCLinkM(PCLinkM), .ResultW(ResultW),
        .RdW(RdW), .RegWriteW(RegWriteW), .ValidW(ValidW), .InstretW(InstretW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       v, rw;
        logic [1:0][4:0]  rd;
        logic [1:0][1:0]  src;
        logic [1:0][2:0]  f3;
        logic [1:0][31:0] alu, rdat, link, eres;
        logic [1:0]       erw;
    } vec_t;

    typedef struct {
        logic [1:0][31:0] res;
        logic [1:0]       rw, v;
        logic [1:0][4:0]  rd;
        logic [63:0]      cnt;
    } exp_t;

    vec_t  vecs[10];
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    logic [63:0] exp_cnt;
    logic [1:0]  vprev;

    function automatic vec_t mk(logic [1:0] v, logic [1:0] rw, logic [4:0] rd0,
        logic [4:0] rd1, logic [1:0] s0, logic [1:0] s1, logic [2:0] f0,
        logic [2:0] f1, logic [31:0] a0, logic [31:0] a1, logic [31:0] d,
        logic [31:0] l0, logic [31:0] l1, logic [31:0] e0, logic [31:0] e1,
        logic [1:0] erw);
        vec_t t;
        t.v = v; t.rw = rw; t.rd[0] = rd0; t.rd[1] = rd1;
        t.src[0] = s0; t.src[1] = s1; t.f3[0] = f0; t.f3[1] = f1;
        t.alu[0] = a0; t.alu[1] = a1; t.rdat[0] = d; t.rdat[1] = d;
        t.link[0] = l0; t.link[1] = l1; t.eres[0] = e0; t.eres[1] = e1;
        t.erw = erw;
        return t;
    endfunction

    function automatic logic [63:0] pc2(logic [1:0] v);
        return 64'(v[0]) + 64'(v[1]);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        ValidM = t.v; RegWriteM = t.rw; RdM = t.rd; ResultSrcM = t.src;
        Funct3M = t.f3; ALUResultM = t.alu; ReadDataM = t.rdat; PCLinkM = t.link;
    endtask

    // Drive at negedge, predict, let one edge pass, then compare against the queue head.
    task automatic step_vec(vec_t t, string name);
        exp_t e;
        @(negedge clk);
        drive(t);
        StallW = 1'b0; FlushW = 1'b0;
        exp_cnt = exp_cnt + pc2(vprev);
        e.res = t.eres; e.rw = t.erw; e.v = t.v; e.rd = t.rd; e.cnt = exp_cnt;
        sb.push_back(e);
        vprev = t.v;
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".res0"}, 64'(ResultW[0]), 64'(e.res[0]));
            chk({name, ".res1"}, 64'(ResultW[1]), 64'(e.res[1]));
            chk({name, ".rw"}, 64'(RegWriteW), 64'(e.rw));
            chk({name, ".valid"}, 64'(ValidW), 64'(e.v));
            chk({name, ".rd"}, 64'(RdW), 64'(e.rd));
            chk({name, ".cnt"}, InstretW, e.cnt);
        end
    endtask

    initial begin
        vec_t t;
        vecs[0] = mk(2'b11, 2'b11, 5, 1, 2'b00, 2'b10, 0, 0, 32'h11, 0, 0,
                     0, 32'h2008, 32'h11, 32'h2008, 2'b11);
        vecs[1] = mk(2'b11, 2'b11, 2, 3, 2'b01, 2'b01, 3'b000, 3'b000, 1, 2,
                     32'h80FF7F01, 0, 0, 32'h7F, 32'hFFFFFFFF, 2'b11);
        vecs[2] = mk(2'b11, 2'b11, 2, 3, 2'b01, 2'b01, 3'b100, 3'b001, 3, 2,
                     32'h80FF7F01, 0, 0, 32'h80, 32'hFFFF80FF, 2'b11);
        vecs[3] = mk(2'b11, 2'b11, 4, 5, 2'b01, 2'b01, 3'b101, 3'b010, 0,
                     32'h103, 32'h80FF7F01, 0, 0, 32'h7F01, 32'h80FF7F01, 2'b11);
        vecs[4] = mk(2'b11, 2'b11, 7, 7, 2'b00, 2'b00, 0, 0, 1, 2, 0, 0, 0,
                     1, 2, 2'b10);
        vecs[5] = mk(2'b11, 2'b11, 0, 9, 2'b00, 2'b00, 0, 0, 3, 4, 0, 0, 0,
                     3, 4, 2'b10);
        vecs[6] = mk(2'b11, 2'b01, 6, 6, 2'b11, 2'b11, 0, 0, 5, 6, 0,
                     32'hBAD, 32'hBAD, 5, 6, 2'b01);
        vecs[7] = mk(2'b10, 2'b11, 4, 4, 2'b00, 2'b00, 0, 0, 8, 9, 0, 0, 0,
                     8, 9, 2'b10);
        vecs[8] = mk(2'b01, 2'b11, 7, 7, 2'b00, 2'b00, 0, 0, 10, 11, 0, 0, 0,
                     10, 11, 2'b01);
        vecs[9] = mk(2'b11, 2'b11, 10, 11, 2'b01, 2'b01, 3'b101, 3'b011, 2, 1,
                     32'h80FF7F01, 0, 0, 32'h80FF, 32'h80FF7F01, 2'b11);

        // Reset with random inputs on the M side.
        rst = 1'b1; StallW = 1'($urandom); FlushW = 1'($urandom);
        ValidM = 2'($urandom); RegWriteM = 2'($urandom); RdM = 10'($urandom);
        ResultSrcM = 4'($urandom); Funct3M = 6'($urandom);
        ALUResultM = {$urandom, $urandom}; ReadDataM = {$urandom, $urandom};
        PCLinkM = {$urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        StallW = 1'b0;
        chk("rst.valid", 64'(ValidW), 0);
        chk("rst.rw", 64'(RegWriteW), 0);
        chk("rst.res", 64'(ResultW), 0);
        chk("rst.rd", 64'(RdW), 0);
        chk("rst.cnt", InstretW, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0; vprev = 2'b00;

        for (int i = 0; i < 10; i++) step_vec(vecs[i], $sformatf("vec%0d", i));

        // Stall for three cycles: held outputs, no writes, frozen count.
        t = mk(2'b11, 2'b11, 5, 6, 2'b00, 2'b00, 0, 0, 32'hA, 32'hB, 0, 0, 0,
               32'hA, 32'hB, 2'b11);
        step_vec(t, "pre_stall");
        @(negedge clk);
        StallW = 1'b1;
        t = mk(2'b11, 2'b11, 8, 9, 2'b00, 2'b00, 0, 0, 32'hDEAD, 32'hBEEF, 0,
               0, 0, 0, 0, 2'b11);
        drive(t);
        #1 chk("stall.rw_now", 64'(RegWriteW), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d.res0", k), 64'(ResultW[0]), 32'hA);
            chk($sformatf("stall%0d.rw", k), 64'(RegWriteW), 0);
            chk($sformatf("stall%0d.cnt", k), InstretW, exp_cnt);
        end
        @(negedge clk);
        StallW = 1'b0;
        #1 chk("unstall.rw", 64'(RegWriteW), 2'b11);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 2;
        chk("unstall.cnt", InstretW, exp_cnt);
        chk("unstall.res0", 64'(ResultW[0]), 32'hDEAD);
        vprev = 2'b11;

        // Flush together with stall: invalidates, does not count.
        @(negedge clk);
        StallW = 1'b1; FlushW = 1'b1;
        @(posedge clk); #1;
        chk("flstall.valid", 64'(ValidW), 0);
        chk("flstall.cnt", InstretW, exp_cnt);
        vprev = 2'b00;
        t = mk(2'b11, 2'b11, 12, 13, 2'b00, 2'b00, 0, 0, 1, 2, 0, 0, 0,
               1, 2, 2'b11);
        step_vec(t, "post_flush");
        // Flush without stall still counts the departing lanes.
        @(negedge clk);
        FlushW = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 2;
        chk("flush.valid", 64'(ValidW), 0);
        chk("flush.cnt", InstretW, exp_cnt);
        vprev = 2'b00;

        // Counter wrap: preload all ones, retire two lanes, expect 1.
        step_vec(t, "pre_wrap");
        @(negedge clk);
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        #1 chk("wrap.preload", InstretW, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap.cnt", InstretW, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
